// File: rtl/fetch_stage.sv
// Instruction fetch stage for the 16-bit mini-MIPS core: PC, single-outstanding imem handshake,
// skid buffer and IF/ID register. Optional FETCH_PREDECODE_EN adds id_illegal predecode.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic [7:0]             redirect_off,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [3:0]             id_op,
  output logic [PC_WIDTH-1:0]    id_pc
`ifdef FETCH_PREDECODE_EN
  ,
  output logic                   id_illegal
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StIssue} state_e;

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic                   jump_q;  // pc_q already holds a redirect target; skip the +1
  logic                   disc_q;  // outstanding response belongs to a flushed path
  logic [INSTR_WIDTH-1:0] skid_q;

  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    next_pc;
  logic                   load_en;
  logic [INSTR_WIDTH-1:0] load_word;

  assign target  = redirect_pc + PC_WIDTH'(1) + {{(PC_WIDTH-8){redirect_off[7]}}, redirect_off};
  assign next_pc = jump_q ? pc_q : pc_q + PC_WIDTH'(1);
  assign id_op   = id_instr[INSTR_WIDTH-1 -: 4];

  always_comb begin
    load_en   = 1'b0;
    load_word = imem_rdata;
    if (!redirect && !stall) begin
      unique case (state_q)
        StWait: load_en = imem_valid && !disc_q;
        StHold: begin
          load_en   = 1'b1;
          load_word = skid_q;
        end
        default: load_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      jump_q    <= 1'b0;
      disc_q    <= 1'b0;
      skid_q    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect) begin
      pc_q   <= target;
      jump_q <= 1'b1;
      if (state_q == StWait && !imem_valid) begin
        // Keep the request up until its response drains, then fetch the target.
        disc_q <= 1'b1;
      end else begin
        disc_q   <= 1'b0;
        imem_req <= 1'b0;
        state_q  <= StIssue;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          imem_req  <= 1'b1;
          imem_addr <= pc_q;
          state_q   <= StWait;
        end
        StWait: begin
          if (imem_valid) begin
            imem_req <= 1'b0;
            if (disc_q) begin
              disc_q  <= 1'b0;
              state_q <= StIssue;
            end else if (!stall) begin
              state_q <= StIssue;
            end else begin
              skid_q  <= imem_rdata;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (!stall) state_q <= StIssue;
        end
        StIssue: begin
          pc_q      <= next_pc;
          imem_addr <= next_pc;
          imem_req  <= 1'b1;
          jump_q    <= 1'b0;
          state_q   <= StWait;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FETCH_PREDECODE_EN
  logic word_illegal;
  assign word_illegal = (load_word[INSTR_WIDTH-1 -: 2] == 2'b11);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
`ifdef FETCH_PREDECODE_EN
      id_illegal <= 1'b0;
`endif
    end else if (redirect) begin
      id_valid   <= 1'b0;
`ifdef FETCH_PREDECODE_EN
      id_illegal <= 1'b0;
`endif
    end else if (!stall) begin
      if (load_en) begin
        id_instr   <= load_word;
        id_pc      <= pc_q;
`ifdef FETCH_PREDECODE_EN
        id_valid   <= !word_illegal;
        id_illegal <= word_illegal;
`else
        id_valid   <= 1'b1;
`endif
      end else begin
        id_valid   <= 1'b0;
`ifdef FETCH_PREDECODE_EN
        id_illegal <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage for the 16-bit mini-MIPS core. It sits directly upstream of the main control decoder. It owns the PC and issues one instruction-memory request at a time over a req/valid handshake. Fetched words are registered into an IF/ID pipeline register, which supplies the 4-bit opcode and operand fields to the decoder. It also accepts stall and taken-branch redirect from the execute side.

Parameters:
PC_WIDTH, 16, width of the program counter and of imem_addr (word-addressed)
INSTR_WIDTH, 16, instruction word width; opcode is always bits [INSTR_WIDTH-1 -: 4]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  request strobe, held high until imem_valid
imem_addr  output  PC_WIDTH  word address of the requested instruction
imem_rdata  input  INSTR_WIDTH  instruction word, qualified by imem_valid
imem_valid  input  1  response valid, at least 1 cycle after req rises
stall  input  1  decode/execute not ready; hold the IF/ID register
redirect  input  1  taken beq/bne resolved this cycle
redirect_pc  input  PC_WIDTH  branch source PC (id_pc of the branch)
redirect_off  input  8  signed off8 from the branch instruction
id_valid  output  1  IF/ID register holds a live instruction
id_instr  output  INSTR_WIDTH  registered instruction word
id_op  output  4  id_instr opcode field, to control decoder
id_pc  output  PC_WIDTH  PC of id_instr

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC
  - imem_req = 0, imem_addr = RESET_PC
  - id_valid = 0, id_instr = 0, id_pc = 0
  - FSM = IDLE
- FSM states:
  - IDLE: on the first cycle after reset release, assert imem_req with imem_addr = pc, then go to WAIT.
  - WAIT: imem_req stays high and imem_addr stays stable. On imem_valid:
    - if the IF/ID register can accept, capture the word and go to ISSUE;
    - otherwise latch the word into a one-entry skid buffer and go to HOLD.
  - HOLD: imem_req = 0. When stall deasserts, move the skid word into IF/ID and go to ISSUE.
  - ISSUE: pc = pc + 1 (wraps modulo 2^PC_WIDTH), assert a request for the new pc, go to WAIT. ISSUE lasts one cycle, so steady-state throughput is 1 instruction per 2 cycles plus memory latency.
- IF/ID register:
  - Loads {instr, pc-of-fetch} with id_valid = 1 when a word arrives and stall = 0.
  - While stall = 1, all id_* outputs hold.
  - When the decoder consumes the entry with no new word arriving, id_valid drops to 0.
  - id_op = id_instr[INSTR_WIDTH-1 -: 4], combinational from the register.
- Redirect (takes priority over everything, including stall):
  - target = redirect_pc + 1 + sign_extend(redirect_off), computed modulo 2^PC_WIDTH.
  - Same cycle: id_valid is cleared (flush) and the skid buffer is emptied.
  - If a request is outstanding (WAIT), its response is still awaited but discarded; then the FSM fetches target.
  - Otherwise the next state is ISSUE with pc = target, with no +1 applied.
- Simultaneous events:
  - redirect and imem_valid in the same cycle: the response is discarded.
  - A second redirect while the discard is pending overwrites target.
- Reset mid-request: the FSM returns to IDLE and any late imem_valid is ignored until a new request is issued.
- Never more than one outstanding request; imem_addr is stable for the whole time imem_req is high.

Optional Feature:
FETCH_PREDECODE_EN
- Defined: adds output id_illegal (1 bit, registered with IF/ID, reset 0).
  - id_illegal is set when the fetched opcode is 4'b1100–4'b1111; in that case id_valid loads 0, which inserts a bubble.
  - The PC still advances normally.
- Undefined: the port is absent and all opcodes pass through unchanged.

Test Plan:
- Reset release, memory returns 0x7123 at addr 0 after 2 cycles → id_valid=1, id_op=4'b0111, id_pc=0; next imem_addr=1.
- Hold stall=1 for 5 cycles while the word for addr 1 returns → id_* unchanged; skid keeps word; after stall drops, id_pc=1 and next fetch addr=2.
- redirect with redirect_pc=0x0010, off=0xFE (-2) while idle → next imem_addr=0x000F; id_valid=0 the following cycle.
- redirect asserted while the addr-5 request is outstanding → the addr-5 response is dropped, never reaching id_valid; next request is the target.
- pc=0xFFFF fetched → next imem_addr=0x0000 (wrap).
- With FETCH_PREDECODE_EN, fetch 0xC000 → id_illegal=1, id_valid=0; without the macro → id_op=4'b1100, id_valid=1.
